controle_fechadura: RTL and testbench
=====================================

# controle_fechadura

Sequencing controller for the serial-entry password lock. Collects password bits one per strobe, compares them against a stored, reprogrammable password, and drives the open/error LEDs for fixed dwell times. Counts consecutive failures and enforces a lockout period. Lets the password be changed only while the lock is open. It sits between the keypad/bit-entry front end and the lock actuator/LED outputs.

## Interface
- SENHA_BITS, 6: password length in bits (2..16)
- SENHA_PADRAO, 6'b101100: password loaded at reset
- MAX_TENTATIVAS, 3: consecutive failures that trigger lockout (1..3)
- T_ABERTO, 8: cycles spent in ABERTO (1..65535)
- T_ERRO, 4: cycles spent in ERRO (1..65535)
- T_BLOQUEIO, 16: cycles spent in BLOQUEADO (1..65535)

- clk  in  1  rising-edge clock; one clock, all state in this domain
- reset_n  in  1  asynchronous, active-low reset
- bit_valido  in  1  qualifies bit_in for one cycle
- bit_in  in  1  password bit, MSB first
- cancelar  in  1  discards the partial entry
- trocar_senha  in  1  requests password programming; honoured only in ABERTO
- led_verde  out  1  lock open / programming
- led_vermelho  out  1  error / lockout / programming
- bloqueado  out  1  lockout active
- tentativas  out  2  current consecutive-failure count

## Operation
- Reset (async, reset_n=0) values:
  - state=DIGITANDO, bit count=0, entry buffer=0
  - senha=SENHA_PADRAO, tentativas=0, timer=0
  - led_verde=0, led_vermelho=0, bloqueado=0
  - Stored password is not retained across reset.
- Outputs are Moore, decoded from registered state:
  - DIGITANDO, VERIFICA: 0/0/0
  - ABERTO: verde=1
  - ERRO: vermelho=1
  - BLOQUEADO: vermelho=1, bloqueado=1
  - PROGRAMANDO: verde=1, vermelho=1
- DIGITANDO:
  - On bit_valido, buffer <= {buffer[SENHA_BITS-2:0], bit_in} and count++.
  - When the accepted bit is the SENHA_BITS-th, count returns to 0 and state goes to VERIFICA.
  - cancelar clears count and buffer and has priority over a same-cycle bit_valido.
- VERIFICA lasts exactly 1 cycle:
  - Match: tentativas <= 0, go to ABERTO.
  - Mismatch with tentativas+1 == MAX_TENTATIVAS: go to BLOQUEADO, tentativas <= MAX_TENTATIVAS.
  - Other mismatch: tentativas++, go to ERRO.
- ABERTO, ERRO and BLOQUEADO:
  - On entry, a 16-bit down-counter loads T-1, so each state lasts exactly T cycles.
  - On expiry the state goes to DIGITANDO.
  - BLOQUEADO expiry also clears tentativas.
  - bit_valido and cancelar are ignored in these states.
- ABERTO with trocar_senha=1 goes to PROGRAMANDO next cycle, with count and buffer cleared. If the timer expires in the same cycle, trocar_senha wins.
- PROGRAMANDO:
  - Shifts bits exactly as DIGITANDO does.
  - After the SENHA_BITS-th bit, senha <= new buffer value and state goes to DIGITANDO.
  - cancelar goes to DIGITANDO with senha unchanged.
  - No timeout in this state.
- Buffer, senha and comparison are all SENHA_BITS wide. The tentativas counter saturates at MAX_TENTATIVAS and never wraps.

## Timing
- Last bit accepted at edge k: VERIFICA is active between edge k and edge k+1, and the result state is visible after edge k+1. Latency is 1 cycle from last bit to LED change.
- Bits spaced arbitrarily: cycles with bit_valido=0 hold count and buffer.
- Back-to-back strobes are accepted every cycle. A strobe during VERIFICA is dropped.
- ABERTO/ERRO/BLOQUEADO outputs stay asserted for exactly T_ABERTO/T_ERRO/T_BLOQUEIO cycles. The next edge accepts bits in DIGITANDO.
- reset_n asserted mid-operation: outputs clear immediately (asynchronously). Release is sampled at the next rising edge.

## Test plan
- Reset, then enter 1,0,1,1,0,0 on 6 consecutive cycles:
  - VERIFICA on cycle 7, led_verde=1 for exactly 8 cycles, tentativas=0.
- Enter 000000:
  - led_vermelho=1 for 4 cycles, tentativas=1.
  - Then a correct entry opens the lock and tentativas returns to 0.
- Three wrong entries in a row:
  - Third gives bloqueado=1 and led_vermelho=1 for 16 cycles, tentativas=3.
  - Bits sent during lockout are ignored.
  - After lockout, tentativas=0 and the correct password opens the lock.
- Enter 3 bits, then cancelar together with bit_valido, then 101100:
  - Lock opens, showing the partial entry and the same-cycle bit were discarded.
- In ABERTO, assert trocar_senha, then enter 010011:
  - Returns to DIGITANDO.
  - 101100 now gives ERRO and 010011 opens.
  - Asserting reset_n=0 restores 101100.
- Assert reset_n=0 mid-entry (after 4 bits) and during ABERTO:
  - All outputs 0 immediately.
  - A full 6-bit entry is required afterwards.

Source files
------------

// File: rtl/controle_fechadura.sv
// Serial-entry password lock sequencer: shifts in password bits, verifies them,
// and times the open / error / lockout indications; reprogramming only while open.
module controle_fechadura #(
  parameter int                    SENHA_BITS     = 6,
  parameter logic [SENHA_BITS-1:0] SENHA_PADRAO   = 6'b101100,
  parameter int                    MAX_TENTATIVAS = 3,
  parameter int                    T_ABERTO       = 8,
  parameter int                    T_ERRO         = 4,
  parameter int                    T_BLOQUEIO     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bit_valido,
  input  logic       bit_in,
  input  logic       cancelar,
  input  logic       trocar_senha,
  output logic       led_verde,
  output logic       led_vermelho,
  output logic       bloqueado,
  output logic [1:0] tentativas
);

  localparam int                CNT_W          = (SENHA_BITS > 2) ? $clog2(SENHA_BITS) : 1;
  localparam logic [CNT_W-1:0]  ULTIMO         = CNT_W'(SENHA_BITS - 1);
  localparam logic [15:0]       CARGA_ABERTO   = 16'(T_ABERTO - 1);
  localparam logic [15:0]       CARGA_ERRO     = 16'(T_ERRO - 1);
  localparam logic [15:0]       CARGA_BLOQUEIO = 16'(T_BLOQUEIO - 1);
  localparam logic [1:0]        TENT_MAX       = 2'(MAX_TENTATIVAS);

  typedef enum logic [2:0] {
    DIGITANDO,
    VERIFICA,
    ABERTO,
    ERRO,
    BLOQUEADO,
    PROGRAMANDO
  } estado_t;

  estado_t               estado, estado_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [SENHA_BITS-1:0] entrada, entrada_nxt;
  logic [SENHA_BITS-1:0] senha, senha_nxt;
  logic [1:0]            tent, tent_nxt;
  logic [15:0]           timer, timer_nxt;
  logic [SENHA_BITS-1:0] entrada_desl;
  logic [2:0]            tent_mais_um;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado  <= DIGITANDO;
      cnt     <= '0;
      entrada <= '0;
      senha   <= SENHA_PADRAO;
      tent    <= '0;
      timer   <= '0;
    end else begin
      estado  <= estado_nxt;
      cnt     <= cnt_nxt;
      entrada <= entrada_nxt;
      senha   <= senha_nxt;
      tent    <= tent_nxt;
      timer   <= timer_nxt;
    end
  end

  always_comb begin
    estado_nxt   = estado;
    cnt_nxt      = cnt;
    entrada_nxt  = entrada;
    senha_nxt    = senha;
    tent_nxt     = tent;
    timer_nxt    = timer;
    entrada_desl = {entrada[SENHA_BITS-2:0], bit_in};
    tent_mais_um = {1'b0, tent} + 3'd1;

    case (estado)
      // Entry and programming share the shifter; only the completion action differs
      DIGITANDO, PROGRAMANDO: begin
        if (cancelar) begin
          cnt_nxt     = '0;
          entrada_nxt = '0;
          estado_nxt  = DIGITANDO;
        end else if (bit_valido) begin
          entrada_nxt = entrada_desl;
          if (cnt == ULTIMO) begin
            cnt_nxt = '0;
            if (estado == PROGRAMANDO) begin
              senha_nxt  = entrada_desl;
              estado_nxt = DIGITANDO;
            end else begin
              estado_nxt = VERIFICA;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      VERIFICA: begin
        if (entrada == senha) begin
          tent_nxt   = '0;
          timer_nxt  = CARGA_ABERTO;
          estado_nxt = ABERTO;
        end else if (tent_mais_um == {1'b0, TENT_MAX}) begin
          tent_nxt   = TENT_MAX;
          timer_nxt  = CARGA_BLOQUEIO;
          estado_nxt = BLOQUEADO;
        end else begin
          tent_nxt   = tent_mais_um[1:0];
          timer_nxt  = CARGA_ERRO;
          estado_nxt = ERRO;
        end
      end
      ABERTO: begin
        if (trocar_senha) begin
          cnt_nxt     = '0;
          entrada_nxt = '0;
          estado_nxt  = PROGRAMANDO;
        end else if (timer == 16'd0) begin
          estado_nxt = DIGITANDO;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      ERRO: begin
        if (timer == 16'd0) estado_nxt = DIGITANDO;
        else                timer_nxt  = timer - 16'd1;
      end
      BLOQUEADO: begin
        if (timer == 16'd0) begin
          tent_nxt   = '0;
          estado_nxt = DIGITANDO;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      default: estado_nxt = DIGITANDO;
    endcase
  end

  // Moore outputs straight from the state register so reset clears them at once
  always_comb begin
    led_verde    = 1'b0;
    led_vermelho = 1'b0;
    bloqueado    = 1'b0;
    case (estado)
      ABERTO:      led_verde = 1'b1;
      ERRO:        led_vermelho = 1'b1;
      BLOQUEADO: begin
        led_vermelho = 1'b1;
        bloqueado    = 1'b1;
      end
      PROGRAMANDO: begin
        led_verde    = 1'b1;
        led_vermelho = 1'b1;
      end
      default: ;
    endcase
  end

  assign tentativas = tent;

endmodule

// File: tb/tb_controle_fechadura.sv
// Directed bench for controle_fechadura: entry, errors, lockout, cancel,
// reprogramming and asynchronous reset, all against hand-computed values.
module tb_controle_fechadura;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bit_valido = 1'b0;
  logic       bit_in = 1'b0;
  logic       cancelar = 1'b0;
  logic       trocar_senha = 1'b0;
  logic       led_verde;
  logic       led_vermelho;
  logic       bloqueado;
  logic [1:0] tentativas;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  controle_fechadura dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bit_valido   (bit_valido),
    .bit_in       (bit_in),
    .cancelar     (cancelar),
    .trocar_senha (trocar_senha),
    .led_verde    (led_verde),
    .led_vermelho (led_vermelho),
    .bloqueado    (bloqueado),
    .tentativas   (tentativas)
  );

  always #5 clk = ~clk;

  // {verde, vermelho, bloqueado, tentativas[1:0]}
  function automatic int saidas();
    return int'({led_verde, led_vermelho, bloqueado, tentativas});
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the last bit's edge.
  task automatic entrar(input logic [5:0] v);
    for (int i = 5; i >= 0; i--) begin
      bit_valido = 1'b1;
      bit_in     = v[i];
      @(negedge clk);
    end
    bit_valido = 1'b0;
    bit_in     = 1'b0;
  endtask

  // Counts consecutive sampled cycles with the selected output high (bounded).
  task automatic contar(input int sel, input bit ruido, output int cnt);
    logic s;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      s = (sel == 0) ? led_verde : (sel == 1) ? led_vermelho : bloqueado;
      if (!s) break;
      cnt++;
      if (ruido) begin
        bit_valido = 1'b1;
        bit_in     = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    bit_valido = 1'b0;
    bit_in     = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", saidas(), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Correct password opens for 8 cycles
    entrar(6'b101100);
    check("verifica_leds", saidas(), 0);
    @(negedge clk);
    check("aberto_outputs", saidas(), 5'b10000);
    contar(0, 1'b0, n);
    check("aberto_dwell", n, 8);
    check("apos_aberto", saidas(), 0);

    // Wrong entry, then correct entry clears the failure count
    entrar(6'b000000);
    @(negedge clk);
    check("erro1_outputs", saidas(), 5'b01001);
    contar(1, 1'b0, n);
    check("erro_dwell", n, 4);
    check("apos_erro_tent", saidas(), 5'b00001);
    entrar(6'b101100);
    @(negedge clk);
    check("reabre_tent0", saidas(), 5'b10000);
    contar(0, 1'b0, n);

    // Three wrong entries lead to lockout; bits during lockout ignored
    entrar(6'b111111);
    @(negedge clk);
    check("erro_a_outputs", saidas(), 5'b01001);
    contar(1, 1'b0, n);
    entrar(6'b010101);
    @(negedge clk);
    check("erro_b_outputs", saidas(), 5'b01010);
    contar(1, 1'b0, n);
    entrar(6'b101101);
    @(negedge clk);
    check("bloqueio_outputs", saidas(), 5'b01111);
    contar(2, 1'b1, n);
    check("bloqueio_dwell", n, 16);
    check("apos_bloqueio", saidas(), 0);
    entrar(6'b101100);
    @(negedge clk);
    check("abre_pos_bloqueio", saidas(), 5'b10000);
    contar(0, 1'b0, n);

    // Partial entry plus a same-cycle cancel/bit are discarded
    for (int i = 0; i < 3; i++) begin
      bit_valido = 1'b1;
      bit_in     = 1'b1;
      @(negedge clk);
    end
    cancelar = 1'b1;
    @(negedge clk);
    cancelar   = 1'b0;
    bit_valido = 1'b0;
    bit_in     = 1'b0;
    check("cancel_sem_verifica", saidas(), 0);
    entrar(6'b101100);
    @(negedge clk);
    check("abre_pos_cancel", saidas(), 5'b10000);

    // Reprogram while open
    @(negedge clk);
    trocar_senha = 1'b1;
    @(negedge clk);
    trocar_senha = 1'b0;
    check("programando_outputs", saidas(), 5'b11000);
    entrar(6'b010011);
    check("fim_programacao", saidas(), 0);
    entrar(6'b101100);
    @(negedge clk);
    check("senha_antiga_erro", saidas(), 5'b01001);
    contar(1, 1'b0, n);
    entrar(6'b010011);
    @(negedge clk);
    check("senha_nova_abre", saidas(), 5'b10000);
    contar(0, 1'b0, n);

    // Reset restores the default password
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    entrar(6'b101100);
    @(negedge clk);
    check("padrao_restaurado", saidas(), 5'b10000);
    contar(0, 1'b0, n);

    // Reset mid-entry discards the partial bits
    entrar(6'b101100);
    @(negedge clk);
    contar(0, 1'b0, n);
    for (int i = 5; i >= 2; i--) begin
      bit_valido = 1'b1;
      bit_in     = (i == 5 || i == 3 || i == 2);
      @(negedge clk);
    end
    bit_valido = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("reset_meio_entrada", saidas(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bit_valido = 1'b1;
      bit_in     = 1'b0;
      @(negedge clk);
    end
    bit_valido = 1'b0;
    repeat (2) @(negedge clk);
    check("sem_abrir_2_bits", saidas(), 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset during ABERTO clears outputs immediately
    entrar(6'b101100);
    @(negedge clk);
    check("aberto_antes_reset", saidas(), 5'b10000);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset_em_aberto", saidas(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("pos_reset_aberto", saidas(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
